// File: rtl/ac_alu_if.sv
// rtl/ac_alu_if.sv - command/operand/result bundle between control unit, bus mux and ac_alu
interface ac_alu_if;
    logic        start;
    logic [2:0]  alu_op;
    logic [15:0] busin;
    logic [15:0] ac;
    logic        busy;
    logic        done;
    logic        z;

    modport master (
        output start, alu_op, busin,
        input  ac, busy, done, z
    );

    modport slave (
        input  start, alu_op, busin,
        output ac, busy, done, z
    );
endinterface

// File: rtl/ac_alu.sv
// rtl/ac_alu.sv - accumulator with single-cycle ops and 8-cycle shift-add 8x8 multiplier
module ac_alu (
    input  logic      clock,
    input  logic      reset,
    ac_alu_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_INC  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    state_t      state_q, state_d;
    logic [15:0] ac_q, ac_d;
    logic        done_q, done_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] prod_next;

    // Next-state logic: command decode in IDLE, one shift-add step per cycle in MULT
    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        prod_next = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.alu_op)
                        OP_LOAD: ac_d = bus.busin;
                        OP_ADD:  ac_d = ac_q + bus.busin;
                        OP_SUB:  ac_d = ac_q - bus.busin;
                        OP_INC:  ac_d = ac_q + 16'd1;
                        OP_CLR:  ac_d = 16'h0000;
                        OP_MUL: begin
                            // Operands are latched so busin may change during the multiply
                            done_d   = 1'b0;
                            state_d  = S_MULT;
                            mcand_d  = {8'h00, bus.busin[7:0]};
                            mplier_d = ac_q[7:0];
                            prod_d   = 16'h0000;
                            cnt_d    = 4'd0;
                        end
                        default: ac_d = ac_q;
                    endcase
                end
            end
            S_MULT: begin
                prod_d   = prod_next;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 4'd1;
                // Eighth step: the last partial product goes straight into ac
                if (cnt_q == 4'd7) begin
                    ac_d    = prod_next;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any multiply in flight without a done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ac_q     <= 16'h0000;
            done_q   <= 1'b0;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            prod_q   <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            ac_q     <= ac_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ac   = ac_q;
    assign bus.busy = (state_q == S_MULT);
    assign bus.done = done_q;
    assign bus.z    = (ac_q == 16'h0000);

endmodule

// File: tb/tb_ac_alu.sv
// tb/tb_ac_alu.sv - self-checking bench for ac_alu with directed and randomized commands
module tb_ac_alu;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ac_alu_if bus ();

    ac_alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference: result of one accepted command from the operation table
    function automatic logic [15:0] ref_result(input logic [2:0] op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (op)
            3'd1:    r = ub;
            3'd2:    r = ua + ub;
            3'd3:    r = ua + 65536 - ub;
            3'd4:    r = (ua % 256) * (ub % 256);
            3'd5:    r = ua + 1;
            3'd6:    r = 0;
            default: r = ua;
        endcase
        r = r % 65536;
        return r[15:0];
    endfunction

    // Present a command for one edge; returns at the following falling edge
    task automatic issue(input logic [2:0] op, input logic [15:0] data);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.busin  = data;
        @(negedge clock);
        bus.start  = 1'b0;
    endtask

    // Count falling edges seen with busy high, bounded
    task automatic wait_mul(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        bus.start  = 1'b0;
        bus.alu_op = 3'd0;
        bus.busin  = 16'h0000;
        reset      = 1'b1;
        #3;
        checks++;
        if (bus.ac !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.z !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: ac=%h busy=%b done=%b z=%b expected ac=0000 busy=0 done=0 z=1",
                     bus.ac, bus.busy, bus.done, bus.z);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_load;
        issue(3'd1, 16'h1234);
        checks++;
        if (bus.ac !== 16'h1234 || bus.done !== 1'b1 || bus.z !== 1'b0) begin
            failures++;
            $display("FAIL load: ac=%h done=%b z=%b expected ac=1234 done=1 z=0", bus.ac, bus.done, bus.z);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.ac !== 16'h1234) begin
            failures++;
            $display("FAIL load_done_pulse: done=%b ac=%h expected done=0 ac=1234", bus.done, bus.ac);
        end
    endtask

    task automatic test_add_sub_inc;
        issue(3'd1, 16'h0001);
        issue(3'd2, 16'hFFFF);
        checks++;
        if (bus.ac !== 16'h0000 || bus.z !== 1'b1 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap: ac=%h z=%b done=%b expected ac=0000 z=1 done=1", bus.ac, bus.z, bus.done);
        end
        issue(3'd3, 16'h0001);
        checks++;
        if (bus.ac !== 16'hFFFF || bus.z !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow: ac=%h z=%b expected ac=ffff z=0", bus.ac, bus.z);
        end
        issue(3'd5, 16'hBEEF);
        checks++;
        if (bus.ac !== 16'h0000 || bus.z !== 1'b1) begin
            failures++;
            $display("FAIL inc_wrap: ac=%h z=%b expected ac=0000 z=1", bus.ac, bus.z);
        end
        issue(3'd0, 16'h7777);
        checks++;
        if (bus.ac !== 16'h0000 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL nop: ac=%h done=%b expected ac=0000 done=1", bus.ac, bus.done);
        end
        issue(3'd7, 16'h7777);
        checks++;
        if (bus.ac !== 16'h0000 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL op7: ac=%h done=%b expected ac=0000 done=1", bus.ac, bus.done);
        end
        @(negedge clock);
    endtask

    task automatic test_mul;
        int cyc;
        issue(3'd1, 16'h000C);
        issue(3'd4, 16'h000D);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.ac !== 16'h000C) begin
            failures++;
            $display("FAIL mul_start: busy=%b done=%b ac=%h expected busy=1 done=0 ac=000c",
                     bus.busy, bus.done, bus.ac);
        end
        bus.busin = 16'hFFFF;
        wait_mul(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL mul_busy_len: cycles=%0d expected 8", cyc);
        end
        checks++;
        if (bus.ac !== 16'h009C || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL mul_result: ac=%h done=%b expected ac=009c done=1", bus.ac, bus.done);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_done_pulse: done=%b busy=%b expected done=0 busy=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_mul_low_bytes;
        int cyc;
        issue(3'd1, 16'hABFF);
        issue(3'd4, 16'h12FF);
        wait_mul(cyc);
        checks++;
        if (bus.ac !== 16'hFE01 || cyc != 8) begin
            failures++;
            $display("FAIL mul_low_bytes: ac=%h cycles=%0d expected ac=fe01 cycles=8", bus.ac, cyc);
        end
        issue(3'd6, 16'h1111);
        checks++;
        if (bus.ac !== 16'h0000 || bus.z !== 1'b1) begin
            failures++;
            $display("FAIL clr: ac=%h z=%b expected ac=0000 z=1", bus.ac, bus.z);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        issue(3'd1, 16'h000C);
        issue(3'd4, 16'h000D);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 20) begin
            cyc++;
            bus.start  = 1'b1;
            bus.alu_op = 3'($urandom_range(0, 7));
            bus.busin  = (cyc % 2 == 0) ? 16'h5555 : 16'($urandom);
            @(negedge clock);
        end
        bus.start = 1'b0;
        checks++;
        if (cyc != 8 || bus.ac !== 16'h009C || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore: cycles=%0d ac=%h done=%b expected cycles=8 ac=009c done=1",
                     cyc, bus.ac, bus.done);
        end
        @(negedge clock);
        checks++;
        if (bus.ac !== 16'h009C || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_queue: ac=%h done=%b expected ac=009c done=0", bus.ac, bus.done);
        end
    endtask

    task automatic test_reset_mid_mul;
        bit seen;
        issue(3'd1, 16'h000C);
        issue(3'd4, 16'h000D);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ac !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.z !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_mul: ac=%h busy=%b done=%b z=%b expected ac=0000 busy=0 done=0 z=1",
                     bus.ac, bus.busy, bus.done, bus.z);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ac !== 16'h0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_abort: late activity seen=%b expected 0", seen);
        end
        issue(3'd1, 16'h5A5A);
        checks++;
        if (bus.ac !== 16'h5A5A || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL load_after_reset: ac=%h done=%b expected ac=5a5a done=1", bus.ac, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_ac [4];
        exp_ac[0] = 16'd10;
        exp_ac[1] = 16'd15;
        exp_ac[2] = 16'd16;
        exp_ac[3] = 16'd13;
        issue(3'd1, 16'd10);
        checks++;
        if (bus.ac !== exp_ac[0] || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_0: ac=%h done=%b expected ac=%h done=1", bus.ac, bus.done, exp_ac[0]);
        end
        issue(3'd2, 16'd5);
        checks++;
        if (bus.ac !== exp_ac[1] || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_1: ac=%h done=%b expected ac=%h done=1", bus.ac, bus.done, exp_ac[1]);
        end
        issue(3'd5, 16'd0);
        checks++;
        if (bus.ac !== exp_ac[2] || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_2: ac=%h done=%b expected ac=%h done=1", bus.ac, bus.done, exp_ac[2]);
        end
        issue(3'd3, 16'd3);
        checks++;
        if (bus.ac !== exp_ac[3] || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_3: ac=%h done=%b expected ac=%h done=1", bus.ac, bus.done, exp_ac[3]);
        end
    endtask

    task automatic test_random;
        logic [15:0] ac_m, d, exp_v;
        logic [2:0]  op;
        int          cyc;
        d = 16'($urandom);
        issue(3'd1, d);
        ac_m = d;
        for (int i = 0; i < 60; i++) begin
            op    = 3'($urandom_range(0, 7));
            d     = 16'($urandom);
            exp_v = ref_result(op, ac_m, d);
            issue(op, d);
            cyc = 8;
            if (op == 3'd4) begin
                bus.busin = 16'($urandom);
                wait_mul(cyc);
            end
            checks++;
            if (bus.ac !== exp_v || bus.done !== 1'b1 || bus.z !== (exp_v == 16'h0000) || cyc != 8) begin
                failures++;
                $display("FAIL random[%0d] op=%0d busin=%h: ac=%h done=%b z=%b cycles=%0d expected ac=%h done=1 cycles=8",
                         i, op, d, bus.ac, bus.done, bus.z, cyc, exp_v);
            end
            ac_m = exp_v;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub_inc();
        test_mul();
        test_mul_low_bytes();
        test_busy_ignore();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ac_alu.md
# ac_alu

Accumulator and arithmetic unit that consumes the 16-bit processor bus. Sits directly downstream of the bus multiplexer. On command from the control unit it loads, adds, subtracts, increments, clears or multiplies into the AC register, using a sequential 8-bit shift-add multiplier for the matrix-multiply inner loop. The AC value feeds back to the bus mux's AC input and to the data memory write path.

## Interface
Parameters:
- none. Widths are fixed: 16-bit bus and AC, 8x8 multiply.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  command strobe; sampled only when busy=0.
- alu_op  in  3  operation code, sampled with start.
- busin  in  16  operand from the bus mux output.
- ac  out  16  accumulator register.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse on completion of any accepted operation.
- z  out  1  combinational; high when ac == 16'h0000.

## Operation
- Op codes:
  - 0 NOP: ac unchanged.
  - 1 LOAD: ac <= busin.
  - 2 ADD: ac <= ac + busin, modulo 2^16.
  - 3 SUB: ac <= ac - busin, modulo 2^16.
  - 4 MUL: ac <= ac[7:0] * busin[7:0], an unsigned 16-bit product.
  - 5 INC: ac <= ac + 1, modulo 2^16.
  - 6 CLR: ac <= 0.
  - 7: reserved; behaves as NOP.
- Carry and borrow are discarded. No overflow flag.
- Accept condition is start=1 and busy=0. NOP and op 7 are still accepted and still pulse done.
- Two-state FSM: IDLE and MULT.
  - IDLE: on accept of ops 0-3 or 5-7, update ac and set done at that edge. Stay in IDLE.
  - IDLE to MULT: on accept of MUL, latch the multiplicand from busin[7:0] and the multiplier from ac[7:0]. Clear the 16-bit product. Load the 4-bit iteration count with 0. Set busy. ac is held.
  - MULT, each edge: if the multiplier LSB is 1, add the multiplicand to the product. Shift the multiplicand left by 1 within a 16-bit register. Shift the multiplier right by 1. Increment the count.
  - MULT to IDLE: on the edge where the count goes 7 to 8, write the final product to ac, clear busy and set done.
- start while busy=1 is ignored, whatever the value of alu_op. There is no queueing.
- Changes on busin during MULT have no effect, because the operands are latched.
- Reset, including mid-multiply, sets:
  - ac=0, busy=0, done=0, z=1;
  - FSM to IDLE;
  - count, product and operand registers cleared;
  - any multiply in progress is aborted with no done pulse.
- The first start after reset deasserts is accepted normally.

## Timing
- Single-cycle ops:
  - accept at edge N;
  - ac holds the new value and done=1 for the cycle after edge N;
  - done returns to 0 at edge N+1 unless another op is accepted at N+1.
  - Back-to-back single-cycle ops can be accepted on every edge.
- MUL:
  - accept at edge N;
  - busy=1 from after edge N until after edge N+8;
  - ac updates at edge N+8, with done=1 for that following cycle;
  - total latency is 8 cycles from accept to result.
  - A new command is accepted no earlier than edge N+9.
- z follows ac combinationally with zero cycle delay.
- busin must be stable at the accepting edge only.

## Test plan
- Reset then LOAD busin=16'h1234 -> ac=16'h1234 one cycle later with a one-cycle done pulse; z=0 during that pulse cycle.
- LOAD 16'h0001 then ADD 16'hFFFF -> ac=16'h0000, z=1. Then SUB 16'h0001 -> ac=16'hFFFF. Then INC -> ac=16'h0000.
- LOAD 16'h000C then MUL busin=16'h000D -> busy high for exactly 8 cycles; then ac=16'h009C (156) and done pulses once.
- LOAD 16'hABFF then MUL busin=16'h12FF -> only the low bytes are used; ac=16'hFE01 (255*255). Then CLR -> ac=0, z=1.
- During a MUL, drive start=1 with LOAD 16'h5555 and toggle busin -> the command is ignored; ac=16'h009C at completion for 12*13.
- Assert reset at the 4th cycle of a MUL -> ac=0, busy=0 and done=0 immediately, with no later done pulse. A LOAD after reset release works normally.
